// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for a synchronous FIFO with a one-cycle
// registered read. It pops the FIFO into a small skid buffer and presents the
// words as a valid/ready stream. The pop request depends only on registered
// occupancy and the FIFO empty flag, so out_ready never reaches fifo_rd_en
// combinationally. The block also counts words delivered and stalled cycles.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state, state_next;
  logic [OCC_W-1:0]        occ, occ_next;
  logic                    inflight;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0]   mem [SKID_DEPTH];
  logic [OCC_W:0]          fill;
  logic                    capture, pop;

  // Pointers wrap explicitly because the depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words held plus the one in flight; a pop is only issued if it fits.
  assign fill       = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (state != FLUSH) && !flush &&
                      (fill < (OCC_W + 1)'(SKID_DEPTH));

  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = out_valid || inflight || (state != IDLE);

  // A flush discards the in-flight word and overrides a same-cycle pop.
  assign capture = inflight && !flush;
  assign pop     = out_valid && out_ready && !flush;

  // Next occupancy and next state.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    occ_next   = occ;
    state_next = state;
    if (capture && !pop)      occ_next = occ + 1'b1;
    else if (!capture && pop) occ_next = occ - 1'b1;

    if (flush) begin
      occ_next   = '0;
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (fifo_rd_en) state_next = STREAM;
        STREAM:  if (occ_next == '0 && fifo_empty) state_next = IDLE;
        FLUSH:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control state: FSM, occupancy, in-flight flag and pointers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state    <= IDLE;
      occ      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      occ      <= occ_next;
      inflight <= fifo_rd_en;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (capture) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Skid storage: written at the tail when the in-flight word lands.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; out_data is masked to zero while empty.
    if (capture) mem[wr_ptr] <= fifo_rd_data;
  end

  // Saturating delivery and stall counters, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (word_count != '1))
        word_count <= word_count + 1'b1;
      if (out_valid && !out_ready && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream. A queue stands in for the upstream FIFO; a
// second queue holds every word taken from it and not yet delivered, which
// gives the expected stream contents, occupancy and pop decisions.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       flush;
  logic       busy;
  logic [15:0] word_count, stall_count;

  // Narrow-counter copy on the same inputs to reach saturation quickly.
  logic       rd_en_s, valid_s, busy_s;
  logic [7:0] data_s;
  logic [3:0] word_count_s, stall_count_s;

  fifo_rd_stream #(.DATA_WIDTH(8), .SKID_DEPTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .busy(busy),
    .word_count(word_count), .stall_count(stall_count)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .SKID_DEPTH(3), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_s),
    .fifo_rd_data(fifo_rd_data), .out_valid(valid_s), .out_data(data_s),
    .out_ready(out_ready), .flush(flush), .busy(busy_s),
    .word_count(word_count_s), .stall_count(stall_count_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ready;
    bit         flush;
    bit         rd_en;
    bit         valid;
    logic [7:0] data;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [7:0] src[$];   // upstream FIFO contents
  logic [7:0] pend[$];  // taken from upstream, not yet delivered (in order)
  logic [7:0] got[$];   // words delivered
  bit  last_rd, prev_flush;
  int  m_wc, m_sc, cyc, first_valid, last_valid, dut_pops, max_out;
  bit  s_rd, s_valid, s_busy;
  logic [7:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic push_words(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) src.push_back(rnd ? 8'($urandom) : 8'(base + i));
  endtask

  // Assert reset at a negedge, check outputs asynchronously, then release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_wc", word_count, 0);
    check("rst_sc", stall_count, 0);
    src.delete(); pend.delete(); got.delete();
    last_rd = 0; prev_flush = 0; m_wc = 0; m_sc = 0; cyc = 0;
    first_valid = -1; last_valid = -1; dut_pops = 0; max_out = 0;
    out_ready = 1'b0; flush = 1'b0; fifo_empty = 1'b1;
    fifo_rd_data = 8'($urandom);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance.
  task automatic step(input bit rdy, input bit fl);
    int         occ;
    bit         exp_valid, exp_rd, exp_busy, accept, stall;
    logic [7:0] exp_data, w;
    out_ready  = rdy;
    flush      = fl;
    fifo_empty = (src.size() == 0);
    #1;
    occ       = pend.size() - int'(last_rd);
    exp_valid = (occ > 0);
    exp_data  = exp_valid ? pend[0] : 8'h00;
    exp_rd    = !fifo_empty && !fl && !prev_flush && (pend.size() < 3);
    exp_busy  = (pend.size() != 0) || prev_flush;
    s_rd = fifo_rd_en; s_valid = out_valid; s_data = out_data; s_busy = busy;

    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("out_data", out_data, exp_data);
    check("fifo_rd_en", fifo_rd_en, exp_rd);
    check("busy", busy, exp_busy);
    check("word_count", word_count, m_wc);
    check("stall_count", stall_count, m_sc);
    check("sat_rd_en", rd_en_s, exp_rd);
    check("sat_word_count", word_count_s, sat15(m_wc));
    check("sat_stall_count", stall_count_s, sat15(m_sc));

    if (fifo_rd_en === 1'b1) dut_pops++;
    if (out_valid === 1'b1) begin
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end

    accept = exp_valid && rdy && !fl;
    stall  = exp_valid && !rdy;
    w = 8'($urandom);
    if (accept) got.push_back(pend[0]);
    if (fl) pend.delete();
    else if (accept) void'(pend.pop_front());
    if (exp_rd) begin
      w = src.pop_front();
      pend.push_back(w);
    end
    if (accept) m_wc++;
    if (stall)  m_sc++;
    last_rd    = exp_rd;
    prev_flush = fl;
    if (dut_pops - got.size() > max_out) max_out = dut_pops - got.size();

    @(posedge clk);
    #1 fifo_rd_data = w;  // registered FIFO read: data lands after the pop edge
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    vec_t tbl[12];
    int   n;
    rst = 1'b1; out_ready = 1'b0; flush = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
    @(negedge clk);

    // Full-rate streaming of 0x01..0x10.
    do_reset();
    push_words(16, 1, 0);
    n = 0;
    while (got.size() < 16 && n < 40) begin step(1, 0); n++; end
    check("s1_count", got.size(), 16);
    check("s1_first_valid_cycle", first_valid, 2);
    check("s1_last_valid_cycle", last_valid, 17);
    for (int i = 0; i < 16 && i < got.size(); i++) check("s1_order", got[i], i + 1);
    check("s1_wc", word_count, 16);
    check("s1_sc", stall_count, 0);

    // Backpressure: ten stalled cycles once data is visible.
    for (int i = 0; i < 12; i++) tbl[i] = '{0, 0, 0, 1, 8'h01};
    tbl[0] = '{0, 0, 1, 0, 8'h00};
    tbl[1] = '{0, 0, 1, 0, 8'h00};
    tbl[2] = '{0, 0, 1, 1, 8'h01};
    do_reset();
    push_words(8, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ready, tbl[i].flush);
      check("t2_rd_en", s_rd, tbl[i].rd_en);
      check("t2_valid", s_valid, tbl[i].valid);
      if (tbl[i].valid) check("t2_data", s_data, tbl[i].data);
    end
    check("t2_pops", dut_pops, 3);
    check("t2_sc", stall_count, 10);
    n = 0;
    while (got.size() < 8 && n < 30) begin step(1, 0); n++; end
    check("t2_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("t2_order", got[i], i + 1);

    // Alternating ready.
    do_reset();
    push_words(12, 0, 1);
    n = 0;
    while (got.size() < 12 && n < 60) begin step(n[0] == 1'b0, 0); n++; end
    check("t3_count", got.size(), 12);
    check("t3_wc", word_count, 12);
    check("t3_max_outstanding_le3", max_out <= 3, 1);

    // Flush with two buffered and one in flight.
    do_reset();
    push_words(8, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0);
    step(0, 1);
    step(1, 0);
    check("t4_valid_after_flush", s_valid, 0);
    check("t4_rd_en_in_flush", s_rd, 0);
    n = 0;
    while (got.size() < 5 && n < 30) begin step(1, 0); n++; end
    check("t4_count", got.size(), 5);
    if (got.size() > 0) check("t4_first_after_flush", got[0], 8'h04);

    // Upstream empties with the last word in flight.
    do_reset();
    push_words(3, 8'h21, 0);
    n = 0;
    while (got.size() < 3 && n < 20) begin step(1, 0); n++; end
    step(1, 0);
    check("t5_count", got.size(), 3);
    check("t5_busy_idle", s_busy, 0);

    // Asynchronous reset with a full buffer, then clean restart.
    do_reset();
    push_words(8, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0);
    check("t6_valid_before_rst", s_valid, 1);
    do_reset();
    push_words(4, 8'h41, 0);
    n = 0;
    while (got.size() < 4 && n < 20) begin step(1, 0); n++; end
    check("t6_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t6_order", got[i], 8'h41 + i);

    // Randomized traffic with occasional flush.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 1) == 1 && src.size() < 20) push_words(1, 0, 1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    check("rand_wc_total", word_count, m_wc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
